gray_rx_checker: RTL and testbench

GRAY_RX_CHECKER -- requirements
Module: gray_rx_checker

---
 rtl/gray_pkg.sv | 17 +
 rtl/gray_to_bin.sv | 16 +
 rtl/gray_rx_checker.sv | 138 +++++++++++++
 tb/tb_gray_rx_checker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared types and default parameters for the Gray-code receive checker.
package gray_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_ERR_CNT_W = 8;
    localparam int DEF_LOCK_CNT  = 2;

    // Wide enough for the largest legal LOCK_CNT (15)
    localparam int GOOD_CNT_W    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } gray_state_t;

endpackage

// File: rtl/gray_to_bin.sv
// Combinational Gray-to-binary decode: each binary bit is the XOR of the
// Gray bits at and above its position.
module gray_to_bin
    import gray_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/gray_rx_checker.sv
// Registered Gray-count receiver: decodes each sample, tracks lock onto a
// +1 sequence and counts illegal steps seen while locked.
//
//   state   | meaning
//   IDLE    | no reference yet; next sample becomes the reference
//   ACQUIRE | reference held, counting consecutive good steps toward lock
//   LOCKED  | stream follows +1 steps; a bad step flags an error
module gray_rx_checker
    import gray_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W,
    parameter int LOCK_CNT  = DEF_LOCK_CNT
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 out_valid,
    output logic                 locked,
    output logic                 step_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam logic [WIDTH-1:0]      REF_ONE  = WIDTH'(1);
    localparam logic [GOOD_CNT_W-1:0] GOOD_ONE = GOOD_CNT_W'(1);
    localparam logic [GOOD_CNT_W-1:0] LOCK_TGT = GOOD_CNT_W'(LOCK_CNT);
    localparam logic [ERR_CNT_W-1:0]  ERR_ONE  = ERR_CNT_W'(1);
    localparam logic [ERR_CNT_W-1:0]  ERR_MAX  = '1;

    gray_state_t state_q, state_d;

    logic [WIDTH-1:0]      ref_q, ref_d;
    logic [GOOD_CNT_W-1:0] good_q, good_d;
    logic [WIDTH-1:0]      dec;
    logic [WIDTH-1:0]      ref_inc;
    logic [GOOD_CNT_W-1:0] good_inc;
    logic                  is_good;
    logic                  is_hold;
    logic [WIDTH-1:0]      bin_d;
    logic                  valid_d;
    logic                  step_d;
    logic                  err_inc;
    logic [ERR_CNT_W-1:0]  err_d;

    gray_to_bin #(
        .WIDTH (WIDTH)
    ) u_dec (
        .gray (gray_in),
        .bin  (dec)
    );

    // Modular +1 so the all-ones to zero wrap counts as a good step
    assign ref_inc  = ref_q + REF_ONE;
    assign good_inc = good_q + GOOD_ONE;
    assign is_good  = (dec == ref_inc);
    assign is_hold  = (dec == ref_q);
    assign locked   = (state_q == LOCKED);

    always_comb begin
        state_d = state_q;
        ref_d   = ref_q;
        good_d  = good_q;
        bin_d   = bin_out;
        valid_d = 1'b0;
        step_d  = 1'b0;
        err_inc = 1'b0;

        if (in_valid) begin
            bin_d   = dec;
            valid_d = 1'b1;
            case (state_q)
                IDLE: begin
                    ref_d   = dec;
                    good_d  = '0;
                    state_d = ACQUIRE;
                end
                ACQUIRE: begin
                    if (is_good) begin
                        ref_d  = dec;
                        good_d = good_inc;
                        if (good_inc == LOCK_TGT) begin
                            state_d = LOCKED;
                        end
                    end else if (!is_hold) begin
                        ref_d  = dec;
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (is_good) begin
                        ref_d = dec;
                    end else if (!is_hold) begin
                        step_d  = 1'b1;
                        err_inc = 1'b1;
                        ref_d   = dec;
                        good_d  = '0;
                        state_d = ACQUIRE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        // A clear in the same cycle as an error leaves the counter at zero
        err_d = err_count;
        if (clear_err) begin
            err_d = '0;
        end else if (err_inc && (err_count != ERR_MAX)) begin
            err_d = err_count + ERR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            ref_q     <= '0;
            good_q    <= '0;
            bin_out   <= '0;
            out_valid <= 1'b0;
            step_err  <= 1'b0;
            err_count <= '0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            good_q    <= good_d;
            bin_out   <= bin_d;
            out_valid <= valid_d;
            step_err  <= step_d;
            err_count <= err_d;
        end
    end

endmodule

// File: tb/tb_gray_rx_checker.sv
// Bench for gray_rx_checker: behavioural model plus per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_gray_rx_checker;

    localparam int W  = 4;
    localparam int EW = 8;
    localparam int LC = 2;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          in_valid  = 1'b0;
    logic [W-1:0]  gray_in   = '0;
    logic          clear_err = 1'b0;
    logic [W-1:0]  bin_out;
    logic          out_valid;
    logic          locked;
    logic          step_err;
    logic [EW-1:0] err_count;

    gray_rx_checker #(
        .WIDTH     (W),
        .ERR_CNT_W (EW),
        .LOCK_CNT  (LC)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .gray_in   (gray_in),
        .clear_err (clear_err),
        .bin_out   (bin_out),
        .out_valid (out_valid),
        .locked    (locked),
        .step_err  (step_err),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model view of the stream: whether a reference exists, the reference
    // value, the run of +1 steps and whether that run has reached lock.
    int m_bin    = 0;
    bit m_valid  = 0;
    bit m_locked = 0;
    bit m_step   = 0;
    int m_err    = 0;
    bit m_seen   = 0;
    int m_ref    = 0;
    int m_streak = 0;
    bit cmp_en   = 0;

    function automatic int to_gray(int b);
        return (b ^ (b >> 1)) & ((1 << W) - 1);
    endfunction

    function automatic int decode(int g);
        int d = 0;
        for (int k = 0; k < W; k++) d = d ^ (g >> k);
        return d & ((1 << W) - 1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge rstn) begin
        m_bin = 0; m_valid = 0; m_locked = 0; m_step = 0;
        m_err = 0; m_seen = 0; m_ref = 0; m_streak = 0;
    end

    always @(posedge clk) begin : model
        int d;
        int diff;
        if (rstn) begin
            m_valid = in_valid;
            m_step  = 0;
            if (in_valid) begin
                d     = decode(int'(gray_in));
                m_bin = d;
                if (!m_seen) begin
                    m_seen = 1; m_ref = d; m_streak = 0; m_locked = 0;
                end else begin
                    diff = (d - m_ref + (1 << W)) % (1 << W);
                    if (diff == 1) begin
                        if (!m_locked) begin
                            m_streak++;
                            if (m_streak >= LC) m_locked = 1;
                        end
                        m_ref = d;
                    end else if (diff != 0) begin
                        if (m_locked) begin
                            m_step = 1;
                            if (m_err < (1 << EW) - 1) m_err++;
                        end
                        m_locked = 0; m_streak = 0; m_ref = d;
                    end
                end
            end
            if (clear_err) m_err = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("bin_out",   int'(bin_out),   m_bin);
            chk("out_valid", int'(out_valid), int'(m_valid));
            chk("locked",    int'(locked),    int'(m_locked));
            chk("step_err",  int'(step_err),  int'(m_step));
            chk("err_count", int'(err_count), m_err);
        end
    end

    task automatic send_g(input int g, input bit clr = 1'b0);
        @(negedge clk);
        in_valid  = 1'b1;
        gray_in   = W'(g);
        clear_err = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int b, input bit clr = 1'b0);
        send_g(to_gray(b % (1 << W)), clr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid  = 1'b0;
            clear_err = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_bin"},    int'(bin_out),   0);
        chk({tag, "_valid"},  int'(out_valid), 0);
        chk({tag, "_locked"}, int'(locked),    0);
        chk({tag, "_step"},   int'(step_err),  0);
        chk({tag, "_err"},    int'(err_count), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("rst_async");
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            gray_in   = W'($urandom);
            clear_err = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        in_valid  = 1'b0;
        clear_err = 1'b0;
        rstn      = 1'b1;
    endtask

    initial begin : stim
        int b;
        int lastb;
        cmp_en = 1;

        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom_range(0, 1));
            gray_in   = W'($urandom);
            clear_err = 1'($urandom_range(0, 1));
        end
        #1;
        chk_all_zero("rst_hold");
        @(negedge clk);
        in_valid = 1'b0; clear_err = 1'b0; rstn = 1'b1;
        send(5);
        chk("first_valid", int'(out_valid), 1);
        chk("first_bin", int'(bin_out), 5);
        chk("first_locked", int'(locked), 0);
        idle(1);

        // Lock sequence followed by repeated hold samples
        do_reset();
        send_g(4'b0000); chk("lock_b0", int'(bin_out), 0); chk("lock_l0", int'(locked), 0);
        send_g(4'b0001); chk("lock_b1", int'(bin_out), 1); chk("lock_l1", int'(locked), 0);
        send_g(4'b0011); chk("lock_b2", int'(bin_out), 2); chk("lock_l2", int'(locked), 1);
        send_g(4'b0010); chk("lock_b3", int'(bin_out), 3); chk("lock_l3", int'(locked), 1);
        for (int i = 0; i < 3; i++) begin
            send_g(4'b0010);
            chk("hold_step", int'(step_err), 0);
            chk("hold_locked", int'(locked), 1);
            chk("hold_err", int'(err_count), 0);
        end
        idle(1);

        // Wrap from all-ones to zero while locked
        do_reset();
        send(11); send(12); send(13);
        chk("wrap_pre_locked", int'(locked), 1);
        send_g(4'b1001); chk("wrap_b14", int'(bin_out), 14); chk("wrap_s14", int'(step_err), 0);
        send_g(4'b1000); chk("wrap_b15", int'(bin_out), 15); chk("wrap_s15", int'(step_err), 0);
        send_g(4'b0000); chk("wrap_b0", int'(bin_out), 0); chk("wrap_s0", int'(step_err), 0);
        chk("wrap_locked", int'(locked), 1);
        idle(1);

        // Illegal step, relock, then error coinciding with clear
        do_reset();
        send(15); send(0); send(1);
        chk("err_pre_locked", int'(locked), 1);
        send_g(4'b0110);
        chk("err_bin", int'(bin_out), 4);
        chk("err_step", int'(step_err), 1);
        chk("err_cnt", int'(err_count), 1);
        chk("err_locked", int'(locked), 0);
        send_g(4'b0111);
        chk("err_step_gone", int'(step_err), 0);
        chk("err_relock_a", int'(locked), 0);
        send_g(4'b0101);
        chk("err_bin6", int'(bin_out), 6);
        chk("err_relock_b", int'(locked), 1);
        send(9, 1'b1);
        chk("clr_step", int'(step_err), 1);
        chk("clr_cnt", int'(err_count), 0);
        idle(1);

        // Saturation: 256 errors, each from a freshly locked stream
        do_reset();
        b = 0;
        send(b);
        for (int k = 1; k <= 256; k++) begin
            send(b + 1); send(b + 2);
            b = (b + 9) % 16;
            send(b);
            chk("sat_step", int'(step_err), 1);
            chk("sat_cnt", int'(err_count), (k > 255) ? 255 : k);
        end
        chk("sat_final", int'(err_count), 255);
        @(negedge clk);
        in_valid = 1'b0; clear_err = 1'b1;
        @(posedge clk); #1;
        chk("idle_clear", int'(err_count), 0);
        idle(1);

        // Mid-stream reset while locked
        send(b + 1); send(b + 2);
        chk("mid_pre_locked", int'(locked), 1);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        chk_all_zero("mid_rst");
        @(negedge clk);
        rstn = 1'b1;
        send_g(4'b0110);
        chk("mid_bin", int'(bin_out), 4);
        chk("mid_valid", int'(out_valid), 1);
        chk("mid_locked", int'(locked), 0);
        chk("mid_step", int'(step_err), 0);
        idle(1);

        // Randomized traffic biased toward +1 steps
        for (int blk = 0; blk < 4; blk++) begin
            do_reset();
            lastb = $urandom_range(0, 15);
            for (int i = 0; i < 150; i++) begin
                int r;
                @(negedge clk);
                r = $urandom_range(0, 9);
                if (r < 6)      lastb = (lastb + 1) % 16;
                else if (r < 8) lastb = lastb;
                else            lastb = $urandom_range(0, 15);
                in_valid  = 1'($urandom_range(0, 9) < 7);
                gray_in   = W'(to_gray(lastb));
                clear_err = 1'($urandom_range(0, 15) == 0);
            end
            idle(2);
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
